// File: rtl/vote_tally_rx.sv
// vote_tally_rx
// Receives 4-bit vote words from the voting controller over a 4-phase
// RTR/CTS handshake and keeps a saturating tally per vote bit plus a
// saturating count of accepted words. A sender that keeps CTS high for
// too long after a capture is flagged, and its word is discarded.
//
// Optional build macro: VOTE_TALLY_LEADER_EN adds LEADER/LEADER_VALID.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   ENABLE       allow new requests
//   CLEAR        synchronous clear of tallies, TOTAL, SAT, TIMEOUT_ERR
//   CTS_IN       sender clear-to-send; V_IN valid while high
//   V_IN[3:0]    vote word from sender
//   RTR_OUT      ready-to-receive request (registered)
//   COUNT_0..3   per-bit saturating tallies
//   TOTAL        saturating count of accepted words
//   SAT[3:0]     SAT[i] high while COUNT_i is all-ones
//   BUSY         high whenever the FSM is not in IDLE
//   TIMEOUT_ERR  sticky flag, CTS held past TIMEOUT cycles in ACK
//   LEADER       (optional) index of the largest tally, lowest index on ties
//   LEADER_VALID (optional) any tally nonzero
//
// State | meaning
//   IDLE   | no request outstanding
//   REQ    | RTR_OUT high, waiting for CTS_IN to capture V_IN
//   ACK    | word captured, waiting for sender to drop CTS_IN
//   UPDATE | one cycle: apply captured word to the tallies
module vote_tally_rx #(
  parameter int WIDTH       = 8,
  parameter int TOTAL_WIDTH = 10,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ENABLE,
  input  logic                   CLEAR,
  input  logic                   CTS_IN,
  input  logic [3:0]             V_IN,
  output logic                   RTR_OUT,
  output logic [WIDTH-1:0]       COUNT_0,
  output logic [WIDTH-1:0]       COUNT_1,
  output logic [WIDTH-1:0]       COUNT_2,
  output logic [WIDTH-1:0]       COUNT_3,
  output logic [TOTAL_WIDTH-1:0] TOTAL,
  output logic [3:0]             SAT,
  output logic                   BUSY,
`ifdef VOTE_TALLY_LEADER_EN
  output logic [1:0]             LEADER,
  output logic                   LEADER_VALID,
`endif
  output logic                   TIMEOUT_ERR
);

  // Down-counter loaded with TIMEOUT-1 on capture; terminal count is 0.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACK    = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic                        rtr_q, rtr_d;
  logic                        busy_q, busy_d;
  logic [3:0]                  cap_q, cap_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic [3:0][WIDTH-1:0]       cnt_q, cnt_d;
  logic [TOTAL_WIDTH-1:0]      total_q, total_d;
  logic [3:0]                  sat_q, sat_d;
  logic                        err_q, err_d;
  // Set on timeout; blocks re-requesting until the stuck sender drops CTS.
  logic                        cts_wait_q, cts_wait_d;
`ifdef VOTE_TALLY_LEADER_EN
  logic [1:0]                  leader_q, leader_d;
  logic                        lvalid_q, lvalid_d;
`endif

  always_comb begin
    state_d    = state_q;
    rtr_d      = rtr_q;
    cap_d      = cap_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    err_d      = err_q;
    cts_wait_d = cts_wait_q;

    if (!CTS_IN) begin
      cts_wait_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (ENABLE && !(cts_wait_q && CTS_IN)) begin
          state_d = S_REQ;
          rtr_d   = 1'b1;
        end
      end
      S_REQ: begin
        // Capture takes priority over ENABLE dropping in the same cycle.
        if (CTS_IN) begin
          cap_d   = V_IN;
          tmo_d   = TMO_LOAD;
          state_d = S_ACK;
          rtr_d   = 1'b0;
        end else if (!ENABLE) begin
          state_d = S_IDLE;
          rtr_d   = 1'b0;
        end
      end
      S_ACK: begin
        if (!CTS_IN) begin
          state_d = S_UPDATE;
        end else if (tmo_q == '0) begin
          err_d      = 1'b1;
          cts_wait_d = 1'b1;
          cap_d      = '0;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_UPDATE: begin
        for (int i = 0; i < 4; i++) begin
          if (cap_q[i] && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        if (total_q != '1) begin
          total_d = total_q + 1'b1;
        end
        cap_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rtr_d   = 1'b0;
      end
    endcase

    // CLEAR dominates, including an update landing in the same cycle.
    if (CLEAR) begin
      cnt_d   = '0;
      total_d = '0;
      err_d   = 1'b0;
    end

    for (int i = 0; i < 4; i++) begin
      sat_d[i] = &cnt_d[i];
    end
    busy_d = (state_d != S_IDLE);
  end

`ifdef VOTE_TALLY_LEADER_EN
  // Works from the registered tallies, so it trails them by one cycle.
  always_comb begin
    leader_d = 2'd0;
    lvalid_d = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (cnt_q[i] > cnt_q[leader_d]) begin
        leader_d = 2'(i);
      end
    end
    lvalid_d = (cnt_q != '0);
    if (CLEAR) begin
      leader_d = 2'd0;
      lvalid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rtr_q      <= 1'b0;
      busy_q     <= 1'b0;
      cap_q      <= '0;
      tmo_q      <= '0;
      cnt_q      <= '0;
      total_q    <= '0;
      sat_q      <= '0;
      err_q      <= 1'b0;
      cts_wait_q <= 1'b0;
`ifdef VOTE_TALLY_LEADER_EN
      leader_q   <= 2'd0;
      lvalid_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rtr_q      <= rtr_d;
      busy_q     <= busy_d;
      cap_q      <= cap_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      sat_q      <= sat_d;
      err_q      <= err_d;
      cts_wait_q <= cts_wait_d;
`ifdef VOTE_TALLY_LEADER_EN
      leader_q   <= leader_d;
      lvalid_q   <= lvalid_d;
`endif
    end
  end

  assign RTR_OUT     = rtr_q;
  assign BUSY        = busy_q;
  assign COUNT_0     = cnt_q[0];
  assign COUNT_1     = cnt_q[1];
  assign COUNT_2     = cnt_q[2];
  assign COUNT_3     = cnt_q[3];
  assign TOTAL       = total_q;
  assign SAT         = sat_q;
  assign TIMEOUT_ERR = err_q;
`ifdef VOTE_TALLY_LEADER_EN
  assign LEADER       = leader_q;
  assign LEADER_VALID = lvalid_q;
`endif

endmodule

// File: doc/vote_tally_rx.md
Name: vote_tally_rx

Overview:
- Downstream consumer of the voting controller's output word.
- Requests a 4-bit vote word over a 4-phase RTR/CTS handshake and captures it on CTS.
- Maintains one saturating tally per vote bit plus a saturating total word count.
- Flags a sender that never releases CTS.

Parameters:
WIDTH, 8, width of each per-bit tally counter
TOTAL_WIDTH, 10, width of total received-word counter
TIMEOUT, 16, max cycles to wait for CTS low after capture (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ENABLE  input  1  allow new requests
CLEAR  input  1  synchronous clear of tallies, TOTAL and TIMEOUT_ERR
CTS_IN  input  1  sender clear-to-send; V_IN valid while high
V_IN  input  4  vote word from sender
RTR_OUT  output  1  ready-to-receive request to sender (registered)
COUNT_0..COUNT_3  output  WIDTH each  tally of words with V_IN[i]=1
TOTAL  output  TOTAL_WIDTH  number of words accepted
SAT  output  4  SAT[i]=1 when COUNT_i is at maximum
BUSY  output  1  high in any state other than IDLE
TIMEOUT_ERR  output  1  sticky; CTS held past TIMEOUT

Behaviour:
- Reset: asynchronous, active-high. All outputs 0; state IDLE; capture register 0; timeout counter 0. Reset asserted mid-handshake drops RTR_OUT immediately and discards the word.
- FSM states: IDLE, REQ, ACK, UPDATE. All outputs registered.
- IDLE:
  - ENABLE=1 -> REQ; RTR_OUT=1 from next cycle.
  - CTS_IN is ignored in IDLE.
- REQ (RTR_OUT=1):
  - CTS_IN=1 sampled -> capture V_IN; go to ACK; RTR_OUT=0 next cycle.
  - Otherwise, ENABLE=0 -> IDLE with RTR_OUT=0.
  - CTS_IN=1 and ENABLE=0 in the same cycle: capture wins.
- ACK (RTR_OUT=0), timeout counter counts cycles in ACK:
  - CTS_IN=0 sampled -> UPDATE.
  - Counter reaches TIMEOUT with CTS_IN still 1 -> set TIMEOUT_ERR, discard the word, go to IDLE.
  - IDLE does not re-request until CTS_IN=0 is seen (IDLE->REQ additionally requires CTS_IN=0).
- UPDATE (1 cycle):
  - For each i with capture[i]=1, COUNT_i += 1.
  - TOTAL += 1 for every accepted word, including 0000.
  - Then go to IDLE.
  - New values are visible on the cycle after UPDATE.
- Saturation: counters hold at all-ones. SAT[i] is registered and goes high in the same cycle COUNT_i reaches max. TOTAL also saturates.
- CLEAR:
  - Zeroes COUNT_*, TOTAL, SAT and TIMEOUT_ERR on the next edge.
  - Does not alter FSM state or RTR_OUT.
  - CLEAR in the UPDATE cycle: clear wins and the word is dropped.
- Minimum transfer cycle from IDLE with ENABLE=1 and an immediately responding sender: IDLE, REQ, ACK, UPDATE (4 cycles).
- V_IN is sampled only in the REQ capture cycle; changes at any other time are ignored.

Optional Feature:
- Macro: VOTE_TALLY_LEADER_EN.
- When defined:
  - Adds outputs LEADER (2 bits) and LEADER_VALID (1 bit), both reset to 0.
  - LEADER is the index of the largest COUNT_i; ties resolve to the lowest index.
  - LEADER_VALID=1 when any COUNT_i is nonzero.
  - Both are registered from the counter values, so they lag the counter update by 1 cycle. CLEAR zeroes them together with the counters.
- When undefined: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then ENABLE=1 with sender returning CTS one cycle after RTR and V_IN=4'b1010, CTS held 2 cycles -> RTR_OUT high for exactly 2 cycles; COUNT_1=1, COUNT_3=1, COUNT_0=COUNT_2=0, TOTAL=1 one cycle after UPDATE; BUSY low again.
- WIDTH=2, send 4'b0001 five times -> COUNT_0 goes 1,2,3,3,3; SAT[0] set after the third word; TOTAL=5.
- Sender holds CTS high 20 cycles with TIMEOUT=16 -> TIMEOUT_ERR=1 after 16 ACK cycles; counters unchanged; no new RTR_OUT until CTS drops. CLEAR then -> TIMEOUT_ERR=0.
- ENABLE drops while in REQ with CTS low -> RTR_OUT falls next cycle, FSM in IDLE. Repeat with CTS high in the same cycle -> word captured and counted.
- CLEAR asserted in the UPDATE cycle of word 4'b1111 -> all counters and TOTAL 0. Async reset pulse in ACK -> RTR_OUT=0 and BUSY=0 immediately.
- With VOTE_TALLY_LEADER_EN defined, send 0100, 0100, 0010, 0010 -> LEADER=1, LEADER_VALID=1 (tie resolves to lower index); send 0100 again -> LEADER=2.
